mem_unit: RTL and testbench
===========================

MEM_UNIT -- requirements
Module: mem_unit

Interface
REQ-001 Parameter MEM_DEPTH, default 9: number of 8-bit words, addresses 0..MEM_DEPTH-1.
REQ-002 Parameter READ_LAT, default 2: wait cycles between read capture and response, range 1..7.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 rd_req  input  1  read request level from control unit; a rising edge starts a read.
REQ-006 mar  input  8  read address, sampled on the cycle the rd_req rising edge is detected.
REQ-007 mbr  output  8  read data; holds last returned value between reads.
REQ-008 rd_ack  output  1  one-cycle pulse, mbr valid in the same cycle.
REQ-009 addr_err  output  1  high with rd_ack when the sampled mar >= MEM_DEPTH; low otherwise.
REQ-010 ld_valid  input  1  program-load data valid.
REQ-011 ld_data  input  8  program-load word.
REQ-012 ld_ready  output  1  high while the block accepts load words.
REQ-013 ld_done  output  1  high once all MEM_DEPTH words are loaded; stays high until reset.
REQ-014 busy  output  1  high in LOAD, WAIT and RESP states.

Function
REQ-015 FSM states: LOAD, IDLE, WAIT, RESP; reset state LOAD.
REQ-016 LOAD: ld_ready=1; each cycle with ld_valid=1 writes ld_data to mem[ld_ptr] and increments ld_ptr.
REQ-017 LOAD: when the word at address MEM_DEPTH-1 is written, next state IDLE, ld_done=1 and ld_ready=0 from the next cycle.
REQ-018 ld_ptr never wraps; ld_valid outside LOAD is ignored and writes nothing.
REQ-019 rd_req is registered once; a rising edge is rd_req=1 with the previous-cycle registered value 0.
REQ-020 IDLE: on a detected rising edge, capture mar into an address register, load the wait counter with READ_LAT, and go to WAIT.
REQ-021 WAIT: decrement the counter each cycle; go to RESP in the cycle after the counter reaches 1, giving exactly READ_LAT WAIT cycles.
REQ-022 RESP (one cycle): rd_ack=1 with mbr=mem[addr] and addr_err=0, or mbr=8'h00 and addr_err=1 if addr >= MEM_DEPTH; next state IDLE.
REQ-023 Latency: edge detected in IDLE at cycle N -> rd_ack at cycle N+READ_LAT+1.
REQ-024 Rising edges detected in LOAD, WAIT or RESP are dropped: no ack, no queued read.
REQ-025 A rising edge detected in the IDLE cycle right after RESP is accepted normally.
REQ-026 mar changes after capture do not affect the data returned.
REQ-027 mbr updates only in RESP; rd_ack and addr_err are 0 in every other state.

Reset
REQ-028 When reset=0, asynchronously: state=LOAD, ld_ptr=0, all mem words=8'h00, mbr=8'h00, rd_ack=0, addr_err=0, ld_done=0, busy=1, ld_ready=1, wait counter=0, rd_req register=0.
REQ-029 Reset asserted mid-load or mid-read aborts the operation: no ack is issued and loading restarts at address 0 after release.
REQ-030 ld_ready becomes 1 immediately when reset asserts and stays 1 after release; first write on the first rising clock edge with reset=1 and ld_valid=1.

Verification
REQ-031 Load 9 words 8'h10..8'h18 with ld_valid held high -> ld_done=1 and ld_ready=0 after the 9th edge; a 10th word is not written.
REQ-032 After load, rd_req rises with mar=3 -> rd_ack pulses exactly 3 cycles after detection, mbr=8'h13, addr_err=0; mbr holds 8'h13 afterwards.
REQ-033 mar=9 read -> rd_ack with mbr=8'h00, addr_err=1; next read of mar=0 returns 8'h10 with addr_err=0.
REQ-034 Second rd_req rising edge during WAIT -> exactly one rd_ack; rd_req held high through RESP -> no second ack.
REQ-035 ld_valid gaps during load (words written on alternate cycles) -> contents correct and ld_done only after the 9th accepted word.
REQ-036 Reset pulsed during WAIT and again after word 4 of a load -> no ack; outputs at the REQ-028 values; reload from address 0 succeeds and reads return the new data.

Source files
------------

// File: rtl/mem_unit_if.sv
// Control-unit <-> memory bus: read request/response, program-load stream and status.
// The master drives requests and load words; the slave (mem_unit) returns data and status.
interface mem_unit_if;
    logic       rd_req;
    logic [7:0] mar;
    logic [7:0] mbr;
    logic       rd_ack;
    logic       addr_err;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       ld_done;
    logic       busy;

    modport master (
        output rd_req, mar, ld_valid, ld_data,
        input  mbr, rd_ack, addr_err, ld_ready, ld_done, busy
    );

    modport slave (
        input  rd_req, mar, ld_valid, ld_data,
        output mbr, rd_ack, addr_err, ld_ready, ld_done, busy
    );
endinterface

// File: rtl/mem_unit.sv
// Program memory: streamed load of MEM_DEPTH bytes, then edge-triggered reads answered READ_LAT+1 cycles after detection.
// Load accepts a word every cycle ld_valid is high while ld_ready; read edges arriving while busy are dropped, not queued.
module mem_unit #(
    parameter int MEM_DEPTH = 9,
    parameter int READ_LAT  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_unit_if.slave  bus
);

    localparam int PTR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] ld_ptr_q, ld_ptr_d;
    logic [7:0]       addr_q, addr_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [7:0]       mbr_q, mbr_d;
    logic             rd_req_q;
    logic [7:0]       mem_q [MEM_DEPTH];

    logic             rd_rise;
    logic             addr_ok;
    logic [7:0]       rd_word;
    logic             ld_we;

    assign rd_rise = bus.rd_req & ~rd_req_q;
    assign addr_ok = (32'(addr_q) < 32'(MEM_DEPTH));
    assign rd_word = addr_ok ? mem_q[addr_q[PTR_W-1:0]] : 8'h00;
    assign ld_we   = (state_q == ST_LOAD) && bus.ld_valid;

    always_comb begin
        state_d  = state_q;
        ld_ptr_d = ld_ptr_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        mbr_d    = mbr_q;
        case (state_q)
            ST_LOAD: begin
                if (bus.ld_valid) begin
                    // Pointer parks on the last address so it can never wrap.
                    if (ld_ptr_q == PTR_W'(MEM_DEPTH - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        ld_ptr_d = ld_ptr_q + 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (rd_rise) begin
                    addr_d  = bus.mar;
                    cnt_d   = 3'(READ_LAT);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 3'd1) begin
                    state_d = ST_RESP;
                    mbr_d   = rd_word;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_LOAD;
            ld_ptr_q <= '0;
            addr_q   <= 8'h00;
            cnt_q    <= 3'd0;
            mbr_q    <= 8'h00;
            rd_req_q <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q  <= state_d;
            ld_ptr_q <= ld_ptr_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            mbr_q    <= mbr_d;
            rd_req_q <= bus.rd_req;
            if (ld_we) begin
                mem_q[ld_ptr_q] <= bus.ld_data;
            end
        end
    end

    // mbr is loaded on the WAIT->RESP edge so it is valid alongside rd_ack.
    assign bus.mbr      = mbr_q;
    assign bus.rd_ack   = (state_q == ST_RESP);
    assign bus.addr_err = (state_q == ST_RESP) && !addr_ok;
    assign bus.ld_ready = (state_q == ST_LOAD);
    assign bus.ld_done  = (state_q != ST_LOAD);
    assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_unit.sv
// Directed bench for mem_unit: load, reads, dropped edges, back-to-back reads and reset aborts.
module tb_mem_unit;

    logic clk = 1'b0;
    logic rst_n;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    mem_unit_if bus();

    mem_unit #(.MEM_DEPTH(9), .READ_LAT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Snapshot order: {mbr, rd_ack, addr_err, ld_done, busy, ld_ready}
    task automatic test_reset();
        logic [12:0] got;
        rst_n        = 1'b0;
        bus.rd_req   = 1'b0;
        bus.mar      = 8'h00;
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'h00;
        #3;
        got = {bus.mbr, bus.rd_ack, bus.addr_err, bus.ld_done, bus.busy, bus.ld_ready};
        vec_cnt++;
        if (got !== 13'h003) begin
            err_cnt++;
            $display("FAIL reset_outputs: got %h want %h", got, 13'h003);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        got = {bus.mbr, bus.rd_ack, bus.addr_err, bus.ld_done, bus.busy, bus.ld_ready};
        vec_cnt++;
        if (got !== 13'h003) begin
            err_cnt++;
            $display("FAIL reset_release: got %h want %h", got, 13'h003);
        end
    endtask

    task automatic test_load();
        logic [1:0] exp;
        bus.ld_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.ld_data = 8'h10 + 8'(i);
            step();
            exp = (i == 8) ? 2'b10 : 2'b01;
            vec_cnt++;
            if ({bus.ld_done, bus.ld_ready} !== exp) begin
                err_cnt++;
                $display("FAIL load_word%0d done/ready: got %b want %b", i, {bus.ld_done, bus.ld_ready}, exp);
            end
        end
        bus.ld_data = 8'hFF;
        step();
        bus.ld_valid = 1'b0;
        vec_cnt++;
        if ({bus.ld_done, bus.ld_ready, bus.busy} !== 3'b100) begin
            err_cnt++;
            $display("FAIL load_idle: got %b want %b", {bus.ld_done, bus.ld_ready, bus.busy}, 3'b100);
        end
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [7:0] exp_dat, input logic exp_err, input string name);
        logic [1:0] exp;
        bus.mar    = addr;
        bus.rd_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 1) begin
                bus.rd_req = 1'b0;
                bus.mar    = ~addr;
            end
            exp = (k == 3) ? {1'b1, exp_err} : 2'b00;
            vec_cnt++;
            if ({bus.rd_ack, bus.addr_err} !== exp) begin
                err_cnt++;
                $display("FAIL %s ack/err cycle%0d: got %b want %b", name, k, {bus.rd_ack, bus.addr_err}, exp);
            end
            if (k == 3) begin
                vec_cnt++;
                if (bus.mbr !== exp_dat) begin
                    err_cnt++;
                    $display("FAIL %s mbr: got %h want %h", name, bus.mbr, exp_dat);
                end
            end
        end
        vec_cnt++;
        if (bus.mbr !== exp_dat) begin
            err_cnt++;
            $display("FAIL %s mbr_hold: got %h want %h", name, bus.mbr, exp_dat);
        end
    endtask

    task automatic test_reads();
        do_read(8'd3, 8'h13, 1'b0, "read3");
        do_read(8'd9, 8'h00, 1'b1, "read9_err");
        do_read(8'd0, 8'h10, 1'b0, "read0");
        do_read(8'd8, 8'h18, 1'b0, "read8");
    endtask

    task automatic test_edge_in_wait();
        int acks = 0;
        bus.mar    = 8'd2;
        bus.rd_req = 1'b1;
        step();
        bus.rd_req = 1'b0;
        step();
        bus.rd_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (bus.rd_ack) acks++;
        end
        bus.rd_req = 1'b0;
        vec_cnt++;
        if (acks != 1) begin
            err_cnt++;
            $display("FAIL edge_in_wait acks: got %0d want 1", acks);
        end
        vec_cnt++;
        if (bus.mbr !== 8'h12) begin
            err_cnt++;
            $display("FAIL edge_in_wait mbr: got %h want %h", bus.mbr, 8'h12);
        end
        step();
    endtask

    task automatic test_back_to_back();
        bus.mar    = 8'd1;
        bus.rd_req = 1'b1;
        step();
        bus.rd_req = 1'b0;
        step();
        step();
        vec_cnt++;
        if ({bus.rd_ack, bus.mbr} !== {1'b1, 8'h11}) begin
            err_cnt++;
            $display("FAIL b2b_first: got %b/%h want 1/11", bus.rd_ack, bus.mbr);
        end
        step();
        bus.mar    = 8'd6;
        bus.rd_req = 1'b1;
        step();
        bus.rd_req = 1'b0;
        step();
        vec_cnt++;
        if (bus.rd_ack !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_early_ack: got %b want 0", bus.rd_ack);
        end
        step();
        vec_cnt++;
        if ({bus.rd_ack, bus.mbr} !== {1'b1, 8'h16}) begin
            err_cnt++;
            $display("FAIL b2b_second: got %b/%h want 1/16", bus.rd_ack, bus.mbr);
        end
        step();
    endtask

    task automatic test_edge_in_resp();
        int acks = 0;
        bus.mar    = 8'd7;
        bus.rd_req = 1'b1;
        step();
        bus.rd_req = 1'b0;
        step();
        step();
        vec_cnt++;
        if ({bus.rd_ack, bus.mbr} !== {1'b1, 8'h17}) begin
            err_cnt++;
            $display("FAIL resp_read: got %b/%h want 1/17", bus.rd_ack, bus.mbr);
        end
        bus.rd_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus.rd_ack) acks++;
        end
        bus.rd_req = 1'b0;
        vec_cnt++;
        if (acks != 0) begin
            err_cnt++;
            $display("FAIL edge_in_resp acks: got %0d want 0", acks);
        end
        step();
    endtask

    task automatic test_reset_abort();
        int          acks = 0;
        logic [12:0] got;
        bus.mar    = 8'd5;
        bus.rd_req = 1'b1;
        step();
        bus.rd_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        got = {bus.mbr, bus.rd_ack, bus.addr_err, bus.ld_done, bus.busy, bus.ld_ready};
        vec_cnt++;
        if (got !== 13'h003) begin
            err_cnt++;
            $display("FAIL abort_wait_outputs: got %h want %h", got, 13'h003);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus.rd_ack) acks++;
        end
        vec_cnt++;
        if (acks != 0) begin
            err_cnt++;
            $display("FAIL abort_wait acks: got %0d want 0", acks);
        end
        for (int i = 0; i < 4; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 8'hA0 + 8'(i);
            step();
            bus.ld_valid = 1'b0;
            step();
        end
        rst_n = 1'b0;
        #1;
        got = {bus.mbr, bus.rd_ack, bus.addr_err, bus.ld_done, bus.busy, bus.ld_ready};
        vec_cnt++;
        if (got !== 13'h003) begin
            err_cnt++;
            $display("FAIL abort_load_outputs: got %h want %h", got, 13'h003);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_gap_load();
        for (int i = 0; i < 9; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 8'h20 + 8'(i);
            step();
            bus.ld_valid = 1'b0;
            bus.ld_data  = 8'hEE;
            vec_cnt++;
            if (bus.ld_done !== (i == 8)) begin
                err_cnt++;
                $display("FAIL gap_load_word%0d done: got %b want %b", i, bus.ld_done, (i == 8));
            end
            step();
        end
        do_read(8'd4, 8'h24, 1'b0, "reload_read4");
        do_read(8'd0, 8'h20, 1'b0, "reload_read0");
        do_read(8'd8, 8'h28, 1'b0, "reload_read8");
    endtask

    initial begin
        test_reset();
        test_load();
        test_reads();
        test_edge_in_wait();
        test_back_to_back();
        test_edge_in_resp();
        test_reset_abort();
        test_gap_load();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
